riscv_muldiv_seq: RTL and testbench

RISCV_MULDIV_SEQ -- requirements
Module: riscv_muldiv_seq

---
 rtl/riscv_muldiv_seq.sv | 190 +++++++++++++++++++
 tb/tb_riscv_muldiv_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : riscv_muldiv_seq
// Purpose  : Sequential RISC-V M-extension multiply/divide unit. Multiplies
//            by shift-add, divides by restoring shift-subtract, one bit per
//            cycle over 32 cycles. Divide-by-zero and signed-overflow cases
//            bypass the iteration and finish one cycle after acceptance.
// Ports    : clk      - rising-edge clock
//            rst_n    - synchronous active-low reset
//            start    - request pulse, sampled only while idle
//            funct3   - M-extension op select (MUL..REMU)
//            op_a     - rs1 operand
//            op_b     - rs2 operand
//            busy     - high whenever the unit is not idle
//            done     - one-cycle pulse, o_data valid
//            o_data   - result, held until the next completion
// Revision : 1.0 - initial release
// ============================================================================
module riscv_muldiv_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] o_data
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [5:0] LAST_ITER = 6'd31;

    logic [1:0]  state;
    logic [5:0]  count;
    logic [2:0]  op_q;
    logic        neg_q;
    // hi/lo/mcand are shared by both algorithms:
    //   multiply: hi = running upper product, lo = multiplier (shifting out)
    //             with low product bits shifting in, mcand = multiplicand
    //   divide  : hi = partial remainder, lo = dividend shifting out with
    //             quotient bits shifting in, mcand = divisor
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mcand;
    logic [31:0] result;

    // ------------------------------------------------------------------
    // Acceptance-time decode: signedness, magnitudes and special cases
    // ------------------------------------------------------------------
    logic        is_div;
    logic        a_signed;
    logic        b_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        res_neg;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] special_res;

    always_comb begin
        is_div   = funct3[2];
        // MUL is treated as unsigned: the low product word is the same either way.
        a_signed = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
        b_signed = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
        a_neg    = a_signed & op_a[31];
        b_neg    = b_signed & op_b[31];
        mag_a    = a_neg ? (32'd0 - op_a) : op_a;
        mag_b    = b_neg ? (32'd0 - op_b) : op_b;
        // Remainder takes the dividend's sign; quotient and product take the XOR.
        res_neg  = (is_div & funct3[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = is_div & (op_b == 32'd0);
        div_ovf  = is_div & ~funct3[0] & (op_a == 32'h8000_0000) & (op_b == 32'hFFFF_FFFF);
        special_res = 32'd0;
        if (div_zero) begin
            special_res = funct3[1] ? op_a : 32'hFFFF_FFFF;
        end else if (div_ovf) begin
            special_res = funct3[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // ------------------------------------------------------------------
    // One iteration step for each algorithm
    // ------------------------------------------------------------------
    logic [32:0] add_sum;
    logic [32:0] shifted;
    logic        ge;
    logic [31:0] sub_res;
    logic [31:0] next_hi;
    logic [31:0] next_lo;

    always_comb begin
        add_sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : 33'd0);
        shifted = {hi, lo[31]};
        ge      = (shifted >= {1'b0, mcand});
        // When ge holds the difference is below the divisor, so 32 bits suffice.
        sub_res = shifted[31:0] - mcand;
        if (op_q[2]) begin
            next_hi = ge ? sub_res : shifted[31:0];
            next_lo = {lo[30:0], ge};
        end else begin
            next_hi = add_sum[32:1];
            next_lo = {add_sum[0], lo[31:1]};
        end
    end

    // ------------------------------------------------------------------
    // Final result with sign fix-up, evaluated on the last iteration
    // ------------------------------------------------------------------
    logic [63:0] prod;
    logic [63:0] prod_fix;
    logic [31:0] div_raw;
    logic [31:0] div_fix;
    logic [31:0] final_res;

    always_comb begin
        prod     = {next_hi, next_lo};
        prod_fix = neg_q ? (64'd0 - prod) : prod;
        div_raw  = op_q[1] ? next_hi : next_lo;
        div_fix  = neg_q ? (32'd0 - div_raw) : div_raw;
        if (op_q[2]) begin
            final_res = div_fix;
        end else if (op_q[1:0] == 2'b00) begin
            final_res = prod_fix[31:0];
        end else begin
            final_res = prod_fix[63:32];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            count  <= 6'd0;
            op_q   <= 3'd0;
            neg_q  <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            mcand  <= 32'd0;
            result <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q  <= funct3;
                        neg_q <= res_neg;
                        count <= 6'd0;
                        if (div_zero || div_ovf) begin
                            result <= special_res;
                            state  <= ST_DONE;
                        end else begin
                            hi    <= 32'd0;
                            lo    <= is_div ? mag_a : mag_b;
                            mcand <= is_div ? mag_b : mag_a;
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    hi    <= next_hi;
                    lo    <= next_lo;
                    count <= count + 6'd1;
                    if (count == LAST_ITER) begin
                        result <= final_res;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = (state != ST_IDLE);
    assign done   = (state == ST_DONE);
    assign o_data = result;

endmodule
`default_nettype wire

// File: tb/tb_riscv_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_muldiv_seq
// Purpose  : Directed self-checking bench for riscv_muldiv_seq. Each vector
//            carries a hand-computed result and expected latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_muldiv_seq;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] o_data;

    int n_tests;
    int n_fail;

    riscv_muldiv_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .o_data (o_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one operation, then measure latency (cycles after the start
    // cycle until done) and how many cycles busy was high up to done.
    task automatic run_op(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        int busy_cnt;
        @(negedge clk);
        start  = 1'b1;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        // Scramble operands after acceptance: they must not matter.
        op_a   = ~a;
        op_b   = b ^ 32'h5A5A_0001;
        funct3 = ~f3;
        lat      = 1;
        busy_cnt = 0;
        while (!done && lat < 60) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (busy) busy_cnt++;
        check({tag, "_data"}, o_data, exp);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy"}, busy_cnt, exp_lat);
        @(posedge clk);
        #1;
        check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int dones;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        funct3  = 3'd0;
        op_a    = 32'd0;
        op_b    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_data", o_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Multiply group
        run_op("mul_7_m3",   F_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        // Result must hold while idle
        repeat (4) @(posedge clk);
        #1;
        check("hold_data", o_data, 32'hFFFF_FFEB);
        run_op("mulh_min",   F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_op("mulhu_ff",   F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mulhsu_ff",  F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_op("mul_zero",   F_MUL,    32'h1234_5678, 32'd0,         32'd0,         33);
        run_op("mulh_neg",   F_MULH,   32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 33);

        // Divide group
        run_op("div_m7_2",   F_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        run_op("rem_m7_2",   F_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        run_op("divu_100_7", F_DIVU,   32'd100,       32'd7,         32'd14,        33);
        run_op("remu_100_7", F_REMU,   32'd100,       32'd7,         32'd2,         33);
        run_op("div_20_m6",  F_DIV,    32'd20,        32'hFFFF_FFFA, 32'hFFFF_FFFD, 33);
        run_op("rem_20_m6",  F_REM,    32'd20,        32'hFFFF_FFFA, 32'd2,         33);
        run_op("divu_big",   F_DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33);

        // Special cases
        run_op("divu_by0",   F_DIVU,   32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem_by0",    F_REM,    32'h1234_5678, 32'd0,         32'h1234_5678, 1);
        run_op("div_ovf",    F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",    F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        // Reset during a multiply; start held high during the reset cycle.
        @(negedge clk);
        start  = 1'b1;
        funct3 = F_MUL;
        op_a   = 32'd9;
        op_b   = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_data", o_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);
        check("abort_idle", {31'd0, busy}, 32'd0);

        // Repeated starts and operand changes during CALC.
        @(negedge clk);
        start  = 1'b1;
        funct3 = F_MUL;
        op_a   = 32'd3;
        op_b   = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            start  = (i % 4 == 1);
            funct3 = F_DIVU;
            op_a   = 32'd1000 + i;
            op_b   = 32'd0;
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                check("restart_data", o_data, 32'd15);
            end
            // Stop issuing starts once the unit can accept again.
            if (dones != 0) start = 1'b0;
            if (dones != 0 && !busy) break;
        end
        start = 1'b0;
        check("restart_dones", dones, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
